decodificador_bcd: RTL
======================

DECODIFICADOR_BCD -- requirements
Module: decodificador_bcd

Interface
REQ-001 SHALL have parameter DIGITS, default 4, the number of packed BCD digits at the input; data width W = 4*DIGITS.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to convert bcd_in; sampled only in IDLE.
REQ-005 SHALL have port bcd_in, input, W, packed BCD with digit i in bits [4i+3:4i] and the most significant digit at the top.
REQ-006 SHALL have port binary_out, output, W, unsigned binary result, registered.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in flight (SHIFT state).
REQ-008 SHALL have port done, output, 1, one-cycle completion strobe (DONE state).
REQ-009 SHALL have port err, output, 1, set when the captured input held a digit greater than 9.

Function
REQ-010 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-011 SHALL, in IDLE with start=1 at edge k, capture bcd_in into an internal BCD register, clear the binary shift register and the iteration counter, and enter SHIFT.
REQ-012 SHALL, at that capture edge, go to DONE instead of SHIFT if any captured nibble is greater than 9, setting err=1 and binary_out=0 (done visible 1 cycle after capture).
REQ-013 SHALL perform one reverse double-dabble iteration per SHIFT cycle:
  - shift {bcd_reg, bin_reg} right by 1;
  - then subtract 3 from every BCD digit whose value is at least 8.
REQ-014 SHALL perform exactly W iterations (16 for DIGITS=4) on edges k+1..k+W.
REQ-015 SHALL, on edge k+W, load bin_reg into binary_out, clear err and enter DONE; done is therefore high during the cycle after edge k+W.
REQ-016 SHALL hold done=1 for exactly one cycle, then return to IDLE.
REQ-017 SHALL ignore start in SHIFT and DONE; a start held high is accepted on the first IDLE edge, giving a throughput of one conversion per W+2 cycles.
REQ-018 SHALL hold binary_out and err stable between done strobes; bcd_in changes after capture do not affect the result.
REQ-019 SHALL be exact for all valid inputs 0..10^DIGITS-1; the result never exceeds W bits.
REQ-020 SHALL drive busy=1 only in SHIFT, and SHALL never assert busy and done together.

Reset
REQ-021 SHALL, on rst=1 at any time (including mid-SHIFT), immediately force state=IDLE and binary_out=0, busy=0, done=0, err=0, and clear all internal registers and the counter.
REQ-022 SHALL discard an interrupted conversion: no done is produced for it after rst deasserts.

Structure
REQ-023 SHALL take the state enum (IDLE, SHIFT, DONE) and the DIGITS default from shared package decodificador_bcd_pkg.
REQ-024 SHALL use one combinational sub-module bcd_resta3 (4-bit in/out: subtract 3 if the value is at least 8), instantiated DIGITS times.
REQ-025 SHALL size the iteration counter to $clog2(W)+1 bits.

Verification
REQ-026 SHALL check: bcd_in=16'h1234, start pulse -> busy for 16 cycles, then done for 1 cycle with binary_out=16'd1234 (16'h04D2) and err=0.
REQ-027 SHALL check: bcd_in=16'h9999 -> binary_out=16'h270F; bcd_in=16'h0000 -> binary_out=0, done after 16 busy cycles.
REQ-028 SHALL check: bcd_in=16'h12A4 -> done 1 cycle after capture, err=1, binary_out=0, busy never high; a following valid 16'h0042 -> err=0, binary_out=42.
REQ-029 SHALL check: start re-pulsed and bcd_in changed to 16'h5555 during SHIFT -> ignored, result still 1234; start held high -> next capture only after DONE.
REQ-030 SHALL check: rst asserted at SHIFT iteration 8 -> all outputs 0 asynchronously and no done after release; a subsequent 16'h0007 -> binary_out=7.
REQ-031 SHALL check loopback: codificador_bcd output fed to decodificador_bcd for all 0..9999 -> binary_out equals the original value.

Source files
------------

// File: rtl/decodificador_bcd_pkg.sv
// Shared types and defaults for the BCD-to-binary decoder.
// Keeps the FSM encoding and digit count in one place.
package decodificador_bcd_pkg;

  localparam int DIGITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/decodificador_bcd_resta3.sv
// Per-digit correction for reverse double-dabble.
// Subtracts 3 from a nibble whose value is 8 or more.
module bcd_resta3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/decodificador_bcd.sv
// Sequential packed-BCD to binary converter.
// One reverse double-dabble iteration per SHIFT cycle.
module decodificador_bcd
  import decodificador_bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [4*DIGITS-1:0] binary_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state;
  logic [W-1:0]  bcd_reg;
  logic [W-1:0]  bin_reg;
  logic [CW-1:0] cnt;

  logic [W-1:0]      bcd_sh;
  logic [W-1:0]      bcd_nx;
  logic [W-1:0]      bin_nx;
  logic [DIGITS-1:0] bad;

  assign bcd_sh = {1'b0, bcd_reg[W-1:1]};
  assign bin_nx = {bcd_reg[0], bin_reg[W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_resta3 u_r3 (
      .din  (bcd_sh[4*g +: 4]),
      .dout (bcd_nx[4*g +: 4])
    );
    assign bad[g] = bcd_in[4*g +: 4] > 4'd9;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bcd_reg    <= '0;
      bin_reg    <= '0;
      cnt        <= '0;
      binary_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
            // Invalid digits skip the iterations entirely.
            if (|bad) begin
              state      <= DONE;
              done       <= 1'b1;
              err        <= 1'b1;
              binary_out <= '0;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_nx;
          bin_reg <= bin_nx;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            err        <= 1'b0;
            binary_out <= bin_nx;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
